uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 CLK_FREQ_HZ, 12000000, SOC clock frequency in Hz.
REQ-002 BAUD_RATE, 115200, serial bit rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer division), HALF = DIV/2.
REQ-003 CLK  input  1  single clock for the whole block; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 RXD  input  1  asynchronous serial line, idle high, 8N1 frames, LSB first.
REQ-006 rx_data  output  8  received byte, stable while rx_valid=1.
REQ-007 rx_valid  output  1  byte available in the holding register.
REQ-008 rx_ready  input  1  consumer accepts the byte when rx_valid=1 and rx_ready=1 on the same edge.
REQ-009 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-010 overrun  output  1  sticky flag: a completed byte was dropped because the holding register was full.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 RXD shall pass through a 2-flop synchronizer; all sampling uses the synchronized value rxs.
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: rxs=0 -> START, bit counter loaded with HALF-1.
REQ-015 Bit counter decrements every cycle; a sample is taken when it reaches 0, and the counter then reloads with DIV-1.
REQ-016 START sample: rxs=0 -> DATA, bit index 0; rxs=1 -> IDLE (glitch rejected, no output).
REQ-017 DATA sample: shift rxs into bit[index], LSB first; after the 8th sample -> STOP.
REQ-018 STOP sample: rxs=1 -> deliver byte (REQ-020), then IDLE; rxs=0 -> frame_err=1 for exactly one cycle, byte discarded, then WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rxs=1, then IDLE; no start detection while the line is low (break condition).
REQ-020 Delivery: if rx_valid=0, or rx_valid=1 with rx_ready=1 on the same edge, load rx_data and set rx_valid=1; otherwise drop the new byte and set overrun=1, leaving rx_data unchanged.
REQ-021 rx_valid shall clear on the handshake edge unless a new byte is delivered on that same edge, in which case it stays 1 and rx_data takes the new byte.
REQ-022 overrun shall clear on the next handshake edge; if an overrun and a handshake coincide, the handshake takes priority and no overrun is recorded.
REQ-023 Latency: rx_valid rises on the edge after the stop sample, that sample being HALF+9*DIV cycles after IDLE first sees rxs=0.
REQ-024 rx_ready while rx_valid=0 shall have no effect.

Reset
REQ-025 While RESET=1 on an edge: state=IDLE, counters=0, shift register=0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-026 RESET mid-frame shall abandon the frame with no delivery and no frame_err; reception resumes on the next falling edge after RESET deasserts.

Structure
REQ-027 The FSM state encoding and the DIV/HALF derivation shall live in a shared package, uart_pkg, reused by the existing transmitter.
REQ-028 The 2-flop synchronizer shall be a separate sub-module, sync2 (parameterized reset value); the remaining logic stays in uart_rx.
REQ-029 A compile-time check shall reject configurations with DIV < 4.

Verification (bench parameters: CLK_FREQ_HZ=1000000, BAUD_RATE=100000, so DIV=10)
REQ-030 Send 0xA5 with rx_ready=1 -> rx_valid pulses for one cycle with rx_data=0xA5; frame_err=0, overrun=0; rx_valid rises 95 cycles after the start edge reaches rxs.
REQ-031 Send 0x3C then 0xC3 back-to-back with rx_ready=0 -> rx_data=0x3C held, overrun=1; on one rx_ready pulse rx_valid=0 and overrun=0.
REQ-032 Send 0x55 with the stop bit low -> frame_err is a single-cycle pulse, rx_valid stays 0; hold RXD low 50 cycles -> busy=1 and no new frame starts; RXD high then send 0x12 -> 0x12 is received.
REQ-033 Drive a 3-cycle low glitch on RXD -> returns to IDLE with no rx_valid or frame_err; busy=0 within 10 cycles.
REQ-034 Assert RESET for 1 cycle at the middle of data bit 4 of 0xFF -> no delivery and all outputs at reset values; send 0x81 next -> 0x81 received.
REQ-035 With rx_valid=1 holding 0x11, make the 0x22 stop sample coincide with rx_ready=1 -> rx_valid stays 1, rx_data=0x22, overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divider derivation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int MIN_DIV = 4;

  function automatic int calc_div(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

  function automatic int calc_half(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register, frame error pulse
// and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF  = calc_half(DIV);
  localparam int CNT_W = $clog2(DIV);

  if (DIV < MIN_DIV) begin : g_div_too_small
    $error("uart_rx: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIV - 1);

  logic             rxs;
  rx_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shreg;
  logic             sample, shift_en, deliver, stop_bad;
  logic             handshake, accept;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxs)
  );

  assign sample    = (cnt == '0);
  assign handshake = rx_valid & rx_ready;
  assign accept    = deliver & (~rx_valid | rx_ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
    end
  end

  // Every sampling state counts down to a mid-bit sample, then reloads a full bit time.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_en     = 1'b0;
    deliver      = 1'b0;
    stop_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (sample) begin
          cnt_next = BIT_LOAD;
          if (rxs) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (sample) begin
          cnt_next     = BIT_LOAD;
          shift_en     = 1'b1;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (sample) begin
          cnt_next = BIT_LOAD;
          if (rxs) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A delivery coinciding with a handshake refills the register and wins over overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (shift_en) begin
        shreg[bit_idx] <= rxs;
      end
      frame_err <= stop_bad;
      if (accept) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (handshake) begin
        rx_valid <= 1'b0;
      end
      if (handshake) begin
        overrun <= 1'b0;
      end else if (deliver && !accept) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
